sr_bank_driver: RTL

- Clocked command stage directly upstream of the gated SR latch bank (per-bit set, reset, common gate).
- Accepts one write command at a time over a valid/ready handshake, as a set mask and a reset mask.
- Sequences the latch inputs through setup, gate pulse and hold phases, so latches never see data changing while the gate is high.
- Resolves set/reset overlap before driving the bank and reports completion.

---
 rtl/sr_bank_driver_pkg.sv | 21 ++
 rtl/sr_phase_timer.sv | 26 ++
 rtl/sr_bank_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sr_bank_driver_pkg.sv
// Shared types and helpers for the SR latch bank driver.
package sr_bank_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of a down-counter able to hold (longest phase - 1); never below 1 bit.
  function automatic int timer_width(input int setup_cyc, input int pulse_cyc,
                                     input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter shared by the setup, pulse and hold phases.
module sr_phase_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// Command sequencer for a gated SR latch bank: setup, gate pulse, hold.
// Optional SR_BANK_DRIVER_SHADOW_EN adds a shadow of the expected latch contents.
module sr_bank_driver
  import sr_bank_driver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_set,
  input  logic [WIDTH-1:0] req_rst,
  output logic [WIDTH-1:0] lat_s,
  output logic [WIDTH-1:0] lat_r,
  output logic             lat_c,
  output logic             busy,
  output logic             done,
  output logic             conflict
`ifdef SR_BANK_DRIVER_SHADOW_EN
  ,
  output logic [WIDTH-1:0] shadow_q,
  output logic [WIDTH-1:0] shadow_known
`endif
);

  localparam int TW = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  if (WIDTH < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $error("sr_bank_driver: WIDTH and all phase lengths must be >= 1");
  end

  state_t        state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_exp;

  assign req_ready = (state == IDLE) && !rst;

  sr_phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Timer reload on every phase change, with the new phase length minus one.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC - 1);
        end
      end
      PULSE: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_s    <= '0;
      lat_r    <= '0;
      lat_c    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      done     <= 1'b0;
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Set wins on overlap, matching the latch's own set priority.
            state    <= SETUP;
            lat_s    <= req_set;
            lat_r    <= req_rst & ~req_set;
            busy     <= 1'b1;
            conflict <= |(req_set & req_rst);
          end
        end
        SETUP: begin
          if (tmr_exp) begin
            state <= PULSE;
            lat_c <= 1'b1;
          end
        end
        PULSE: begin
          if (tmr_exp) begin
            state <= HOLD;
            lat_c <= 1'b0;
          end
        end
        HOLD: begin
          if (tmr_exp) begin
            state <= IDLE;
            lat_s <= '0;
            lat_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SR_BANK_DRIVER_SHADOW_EN
  // Latches capture on the gate's falling edge, i.e. the last pulse cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      shadow_known <= '0;
    end else if (state == PULSE && tmr_exp) begin
      shadow_q     <= (shadow_q & ~lat_r) | lat_s;
      shadow_known <= shadow_known | lat_s | lat_r;
    end
  end
`endif

endmodule
